// File: rtl/soc_trace_event_pkg.sv
// Shared types for the MSP430 trace event filter: event kinds, marker
// immediates, the queued event record and the event payload helper.
package soc_trace_event_pkg;

    typedef enum logic [1:0] {
        EVT_TERMINATE = 2'd0,
        EVT_PUTC      = 2'd1,
        EVT_REPORT    = 2'd2
    } evt_kind_t;

    // Low half-word of a marker instruction selecting the event
    localparam logic [15:0] NOP_K_TERMINATE = 16'h0001;
    localparam logic [15:0] NOP_K_REPORT    = 16'h0002;
    localparam logic [15:0] NOP_K_PUTC      = 16'h0004;

    typedef struct packed {
        evt_kind_t   kind;
        logic [31:0] pc;
        logic [31:0] data;
    } trace_event_t;

    // putc carries only the low byte of r3; other events carry all of r3
    function automatic logic [31:0] evt_payload(evt_kind_t kind, logic [31:0] r3);
        return (kind == EVT_PUTC) ? {24'h0, r3[7:0]} : r3;
    endfunction

endpackage

// File: rtl/soc_msp430_trace_event_filter_if.sv
// Trace input bundle plus event output port and status of the filter.
interface soc_msp430_trace_event_filter_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 trace_valid;
    logic [31:0]          trace_pc;
    logic [31:0]          trace_insn;
    logic                 trace_wben;
    logic [4:0]           trace_wbreg;
    logic [31:0]          trace_wbdata;

    logic                 evt_valid;
    logic                 evt_ready;
    logic [1:0]           evt_kind;
    logic [31:0]          evt_pc;
    logic [31:0]          evt_data;

    logic                 terminated;
    logic [CNT_WIDTH-1:0] overflow_cnt;

    // Trace source / event consumer side
    modport master (
        output trace_valid, trace_pc, trace_insn, trace_wben, trace_wbreg, trace_wbdata,
        output evt_ready,
        input  evt_valid, evt_kind, evt_pc, evt_data, terminated, overflow_cnt
    );

    // Filter side
    modport slave (
        input  trace_valid, trace_pc, trace_insn, trace_wben, trace_wbreg, trace_wbdata,
        input  evt_ready,
        output evt_valid, evt_kind, evt_pc, evt_data, terminated, overflow_cnt
    );
endinterface

// File: rtl/soc_trace_event_fifo.sv
// Synchronous first-word-fall-through FIFO of trace events. A push is
// accepted on a full FIFO when a pop frees the head in the same cycle.
module soc_trace_event_fifo
    import soc_trace_event_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  trace_event_t din,
    output logic         full,
    input  logic         pop,
    output logic         empty,
    output trace_event_t dout
);
    localparam int AW = $clog2(DEPTH);

    trace_event_t  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_q];

    // Next pointers and occupancy; pointers wrap naturally at DEPTH
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + AW'(1);
        if (do_pop)  rd_d = rd_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer/occupancy state; reset empties the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: stale entries are never exposed while empty
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/soc_msp430_trace_event_filter.sv
// Per-core trace consumer: shadows r3, decodes marker instructions into
// terminate/putc/report events, and queues them behind a valid/ready port.
module soc_msp430_trace_event_filter
    import soc_trace_event_pkg::*;
#(
    parameter logic [15:0] NOP_OPCODE = 16'h1500,
    parameter int          FIFO_DEPTH = 4,
    parameter int          CNT_WIDTH  = 16
) (
    input  logic clk,
    input  logic rst,
    soc_msp430_trace_event_filter_if.slave bus
);
    logic [31:0]          r3_q, r3_d;
    logic                 term_q, term_d;
    logic [CNT_WIDTH-1:0] ovf_q, ovf_d;

    logic                 in_vld;
    logic                 evt_hit;
    evt_kind_t            evt_kind;
    trace_event_t         evt_in;
    trace_event_t         head;
    logic                 fifo_full, fifo_empty, fifo_pop;

    // Once terminated, the trace stream is ignored entirely
    assign in_vld = bus.trace_valid & ~term_q;

    // Marker decode; unknown immediates produce no event
    always_comb begin
        evt_hit  = 1'b0;
        evt_kind = EVT_REPORT;
        if (in_vld && bus.trace_insn[31:16] == NOP_OPCODE) begin
            case (bus.trace_insn[15:0])
                NOP_K_TERMINATE: begin evt_hit = 1'b1; evt_kind = EVT_TERMINATE; end
                NOP_K_PUTC:      begin evt_hit = 1'b1; evt_kind = EVT_PUTC;      end
                NOP_K_REPORT:    begin evt_hit = 1'b1; evt_kind = EVT_REPORT;    end
                default:         evt_hit = 1'b0;
            endcase
        end
    end

    // Payload uses r3 before this cycle's writeback lands
    assign evt_in = '{kind: evt_kind, pc: bus.trace_pc, data: evt_payload(evt_kind, r3_q)};

    assign fifo_pop = ~fifo_empty & bus.evt_ready;

    // Shadow, sticky terminate and saturating drop counter next-state
    always_comb begin
        r3_d   = r3_q;
        term_d = term_q;
        ovf_d  = ovf_q;
        if (in_vld && bus.trace_wben && bus.trace_wbreg == 5'd3)
            r3_d = bus.trace_wbdata;
        if (evt_hit && evt_kind == EVT_TERMINATE)
            term_d = 1'b1;
        if (evt_hit && fifo_full && !fifo_pop && ovf_q != '1)
            ovf_d = ovf_q + CNT_WIDTH'(1);
    end

    // Filter state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r3_q   <= '0;
            term_q <= 1'b0;
            ovf_q  <= '0;
        end else begin
            r3_q   <= r3_d;
            term_q <= term_d;
            ovf_q  <= ovf_d;
        end
    end

    soc_trace_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (evt_hit),
        .din   (evt_in),
        .full  (fifo_full),
        .pop   (fifo_pop),
        .empty (fifo_empty),
        .dout  (head)
    );

    // Event fields read as zero while nothing is queued
    assign bus.evt_valid    = ~fifo_empty;
    assign bus.evt_kind     = fifo_empty ? 2'd0  : head.kind;
    assign bus.evt_pc       = fifo_empty ? 32'd0 : head.pc;
    assign bus.evt_data     = fifo_empty ? 32'd0 : head.data;
    assign bus.terminated   = term_q;
    assign bus.overflow_cnt = ovf_q;

endmodule

// File: tb/tb_soc_msp430_trace_event_filter.sv
// Directed bench for the trace event filter with hand-computed expectations.
module tb_soc_msp430_trace_event_filter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    soc_msp430_trace_event_filter_if #(.CNT_WIDTH(16)) bus ();

    soc_msp430_trace_event_filter #(
        .NOP_OPCODE (16'h1500),
        .FIFO_DEPTH (4),
        .CNT_WIDTH  (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.trace_valid  = 1'b0;
        bus.trace_pc     = '0;
        bus.trace_insn   = '0;
        bus.trace_wben   = 1'b0;
        bus.trace_wbreg  = '0;
        bus.trace_wbdata = '0;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        bus.trace_valid  = 1'b1;
        bus.trace_pc     = 32'h0000_0040;
        bus.trace_insn   = 32'h4303_0000;
        bus.trace_wben   = 1'b1;
        bus.trace_wbreg  = r;
        bus.trace_wbdata = d;
        tick();
        idle_in();
    endtask

    task automatic marker(input logic [31:0] pc, input logic [15:0] k);
        bus.trace_valid = 1'b1;
        bus.trace_pc    = pc;
        bus.trace_insn  = {16'h1500, k};
        bus.trace_wben  = 1'b0;
        tick();
        idle_in();
    endtask

    task automatic pop();
        bus.evt_ready = 1'b1;
        tick();
        bus.evt_ready = 1'b0;
    endtask

    initial begin
        idle_in();
        bus.evt_ready = 1'b0;

        // Reset / idle
        repeat (3) tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("rst_valid", bus.evt_valid, 0);
        chk("rst_kind", bus.evt_kind, 0);
        chk("rst_pc", bus.evt_pc, 0);
        chk("rst_data", bus.evt_data, 0);
        chk("rst_term", bus.terminated, 0);
        chk("rst_ovf", bus.overflow_cnt, 0);

        // Putc
        wb(5'd3, 32'h0000_0041);
        marker(32'h100, 16'h0004);
        chk("putc_valid", bus.evt_valid, 1);
        chk("putc_kind", bus.evt_kind, 1);
        chk("putc_pc", bus.evt_pc, 32'h100);
        chk("putc_data", bus.evt_data, 32'h41);
        pop();
        chk("putc_popped", bus.evt_valid, 0);

        // putc keeps only low byte; unknown K gives nothing
        wb(5'd3, 32'hABCD_1234);
        marker(32'h104, 16'h0003);
        chk("badk_novalid", bus.evt_valid, 0);
        marker(32'h108, 16'h0004);
        chk("putc_byte", bus.evt_data, 32'h34);
        pop();

        // Same-cycle r3 write uses old value
        wb(5'd3, 32'd5);
        bus.trace_valid  = 1'b1;
        bus.trace_pc     = 32'h200;
        bus.trace_insn   = 32'h1500_0002;
        bus.trace_wben   = 1'b1;
        bus.trace_wbreg  = 5'd3;
        bus.trace_wbdata = 32'd9;
        tick();
        idle_in();
        chk("same_kind", bus.evt_kind, 2);
        chk("same_data", bus.evt_data, 32'd5);
        pop();
        marker(32'h204, 16'h0002);
        chk("same_next", bus.evt_data, 32'd9);
        pop();
        chk("same_empty", bus.evt_valid, 0);

        // Overflow: 6 reports into a 4-deep FIFO
        for (int i = 0; i < 6; i++) begin
            wb(5'd3, 32'h10 + i);
            marker(32'h300 + 4 * i, 16'h0002);
        end
        tick();
        chk("ovf_cnt", bus.overflow_cnt, 2);
        chk("ovf_head", bus.evt_data, 32'h10);
        chk("ovf_head_pc", bus.evt_pc, 32'h300);

        // Pop and push on a full FIFO in the same cycle: no drop
        wb(5'd3, 32'h20);
        bus.evt_ready   = 1'b1;
        bus.trace_valid = 1'b1;
        bus.trace_pc    = 32'h400;
        bus.trace_insn  = 32'h1500_0002;
        tick();
        idle_in();
        bus.evt_ready = 1'b0;
        tick();
        chk("popush_ovf", bus.overflow_cnt, 2);
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", bus.evt_data, (i == 3) ? 32'h20 : 32'h11 + i);
            pop();
        end
        chk("drain_empty", bus.evt_valid, 0);

        // Terminate with FIFO full
        for (int i = 0; i < 4; i++) begin
            wb(5'd3, 32'h30 + i);
            marker(32'h500 + 4 * i, 16'h0002);
        end
        wb(5'd3, 32'h77);
        marker(32'h600, 16'h0001);
        chk("term_set", bus.terminated, 1);
        chk("term_ovf", bus.overflow_cnt, 3);
        wb(5'd3, 32'h99);
        marker(32'h604, 16'h0002);
        chk("term_ignore_ovf", bus.overflow_cnt, 3);
        for (int i = 0; i < 4; i++) begin
            chk("term_drain", bus.evt_data, 32'h30 + i);
            pop();
        end
        chk("term_empty", bus.evt_valid, 0);
        marker(32'h608, 16'h0002);
        chk("term_no_evt", bus.evt_valid, 0);
        chk("term_sticky", bus.terminated, 1);

        // Async reset mid-stream with 3 queued
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("rerst_term", bus.terminated, 0);
        for (int i = 0; i < 5; i++) marker(32'h700 + 4 * i, 16'h0002);
        marker(32'h720, 16'h0001);
        pop();
        chk("pre_valid", bus.evt_valid, 1);
        chk("pre_term", bus.terminated, 1);
        chk("pre_ovf", bus.overflow_cnt, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", bus.evt_valid, 0);
        chk("arst_term", bus.terminated, 0);
        chk("arst_ovf", bus.overflow_cnt, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_valid", bus.evt_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
